axi4_lite_write_arbiter: RTL
============================

Name: axi4_lite_write_arbiter

Overview:
- Shares one AXI4-Lite write master interface among NUM_REQ local requesters.
- Round-robin arbitration; exactly one outstanding write at a time.
- Sequences the AW, W and B channels of the granted write, with programmable valid/ready delays and a B-channel wait watchdog.
- Sits between the write-master driver logic and the AXI4-Lite write bus.

Parameters:
- NUM_REQ, 4: number of requesters (≥2).
- ADDRESS_WIDTH, 32: awaddr width.
- DATA_WIDTH, 32: wdata width; strobe width is DATA_WIDTH/8.
- DELAY_WIDTH, 5: width of delay configuration fields.
- MAX_WAIT_BVALID, 64: B-channel watchdog limit, in cycles.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses; requester i occupies slice i.
- req_prot  in  NUM_REQ*3  packed awprot values.
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*(DATA_WIDTH/8)  packed write strobes.
- awvalid_delay  in  DELAY_WIDTH  cycles from grant to awvalid.
- wvalid_delay  in  DELAY_WIDTH  cycles from grant to wvalid.
- bready_delay  in  DELAY_WIDTH  cycles from RESP entry to bready.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- done_resp  out  2  bresp of the completed write; valid with done.
- bvalid_timeout  out  1  sticky watchdog flag.
- awaddr  out  ADDRESS_WIDTH  AXI write address.
- awprot  out  3  AXI write protection.
- awvalid  out  1  AXI write-address valid.
- awready  in  1  AXI write-address ready.
- wdata  out  DATA_WIDTH  AXI write data.
- wstrb  out  DATA_WIDTH/8  AXI write strobe.
- wvalid  out  1  AXI write-data valid.
- wready  in  1  AXI write-data ready.
- bresp  in  2  AXI write response.
- bvalid  in  1  AXI write-response valid.
- bready  out  1  AXI write-response ready.

Behaviour:
- Reset:
  - State IDLE; priority pointer = 0.
  - Outputs go to 0: gnt, done, done_resp, bvalid_timeout, awvalid, wvalid, bready, awaddr, awprot, wdata, wstrb.
  - Reset mid-transaction drops all valids the next cycle; the in-flight write is abandoned and done does not pulse.
- FSM states: IDLE, ADDR_DATA, RESP, DONE.
- IDLE:
  - If any req is set, pick the first requester at or after the pointer, searching upward and wrapping modulo NUM_REQ.
  - At that edge: capture the winner's payload, the three delays and the winner index; go to ADDR_DATA.
  - gnt[winner] is high for exactly the first ADDR_DATA cycle. Requesters hold req and payload until they see gnt.
  - Pointer = winner+1, wrapping to 0 after NUM_REQ-1.
  - bvalid_timeout clears on every grant.
- ADDR_DATA:
  - Independent AW and W counters load from the captured delays and decrement to 0.
  - awvalid rises when the AW counter is 0; wvalid rises when the W counter is 0. With delay 0, valid is high in the gnt cycle.
  - Once raised, a valid stays high and its payload stays stable until the handshake (valid&ready at an edge); it then drops the next cycle.
  - Per-channel done flags record each handshake. AW and W may complete in either order or in the same cycle.
  - When both flags are set, go to RESP. The earliest case is one cycle after a simultaneous handshake.
  - Ready signals seen before the corresponding valid is raised are ignored.
- RESP:
  - bready rises after bready_delay cycles and stays high until bvalid&bready.
  - On that edge: latch bresp into done_resp, go to DONE, drop bready.
  - Watchdog counts RESP cycles with bvalid low and saturates at MAX_WAIT_BVALID.
  - On reaching the limit, bvalid_timeout goes high and holds. The FSM keeps waiting; the transfer is not aborted.
- DONE:
  - done[winner] is high for one cycle; done_resp is valid in that same cycle.
  - Go to IDLE. Back-to-back grants are possible: the next grant is taken the cycle after DONE.
- Requests raised while the FSM is busy are not sampled; the requester keeps req high until it gets gnt.
- gnt, done and done_resp are registered outputs.

Decomposition:
- The shared package holds:
  - the state enum;
  - an enum matching the existing bresp values (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11);
  - a transfer struct of addr, prot, data, strb and delays;
  - the default widths.
- Sub-module axi4_lite_rr_arbiter: combinational round-robin pick of a winner from req plus pointer, giving a one-hot result and an index. Used once.

Test Plan:
- Single write: req[2] with addr 0x10, data 0xA5A5A5A5, strb 0xF, all delays 0, awready=wready=1, bvalid one cycle after bready with bresp 00 → gnt[2] one cycle; AW and W handshake in the gnt cycle; done[2] with done_resp=00.
- Contention: req=4'b1111 held, each requester dropping on its gnt → grant order 0,1,2,3, one write at a time; pointer returns to 0.
- Channel skew: wready=1, awready low for 3 cycles → W handshake first, wvalid drops, awvalid held with stable awaddr; RESP entered only after the AW handshake.
- Delays: awvalid_delay=3, wvalid_delay=1, bready_delay=2 → awvalid first high 3 cycles after gnt, wvalid 1 cycle after gnt, bready 2 cycles after RESP entry.
- Watchdog: bvalid held low for 70 cycles, then bvalid with bresp 10 → bvalid_timeout high after 64 cycles; done pulses with done_resp=10; flag clears on the next grant.
- Reset mid-write: assert areset while awvalid is high → next cycle all valids 0, no done pulse, state IDLE, pointer 0.

Source files
------------

// File: rtl/axi4_lite_write_arbiter_pkg.sv
// Shared types and default widths for the AXI4-Lite write arbiter.
// Imported by the round-robin picker and by the top.
package axi4_lite_write_arbiter_pkg;

    localparam int DEF_NUM_REQ         = 4;
    localparam int DEF_ADDRESS_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_DELAY_WIDTH     = 5;
    localparam int DEF_MAX_WAIT_BVALID = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_DATA = 2'd1,
        RESP      = 2'd2,
        DONE      = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } bresp_e;

    // Captured write at the default widths; the top declares this same
    // layout sized by its own parameters.
    typedef struct packed {
        logic [DEF_ADDRESS_WIDTH-1:0]   addr;
        logic [2:0]                     prot;
        logic [DEF_DATA_WIDTH-1:0]      data;
        logic [DEF_DATA_WIDTH/8-1:0]    strb;
        logic [DEF_DELAY_WIDTH-1:0]     aw_delay;
        logic [DEF_DELAY_WIDTH-1:0]     w_delay;
        logic [DEF_DELAY_WIDTH-1:0]     b_delay;
    } xfer_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// searching upward and wrapping around.
module axi4_lite_rr_arbiter
    import axi4_lite_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    int cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        cand       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_valid && req[cand]) begin
                win_valid        = 1'b1;
                win_idx          = IDX_W'(cand);
                win_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_write_arbiter.sv
// Shares one AXI4-Lite write master among NUM_REQ requesters, one write
// in flight at a time, with programmable valid/ready delays and a B watchdog.
module axi4_lite_write_arbiter
    import axi4_lite_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int ADDRESS_WIDTH   = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DELAY_WIDTH     = DEF_DELAY_WIDTH,
    parameter int MAX_WAIT_BVALID = DEF_MAX_WAIT_BVALID
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*3-1:0]                req_prot,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_data,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_strb,
    input  logic [DELAY_WIDTH-1:0]              awvalid_delay,
    input  logic [DELAY_WIDTH-1:0]              wvalid_delay,
    input  logic [DELAY_WIDTH-1:0]              bready_delay,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic [NUM_REQ-1:0]                  done,
    output logic [1:0]                          done_resp,
    output logic                                bvalid_timeout,
    output logic [ADDRESS_WIDTH-1:0]            awaddr,
    output logic [2:0]                          awprot,
    output logic                                awvalid,
    input  logic                                awready,
    output logic [DATA_WIDTH-1:0]               wdata,
    output logic [DATA_WIDTH/8-1:0]             wstrb,
    output logic                                wvalid,
    input  logic                                wready,
    input  logic [1:0]                          bresp,
    input  logic                                bvalid,
    output logic                                bready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam int WD_W   = $clog2(MAX_WAIT_BVALID + 1);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [2:0]               prot;
        logic [DATA_WIDTH-1:0]    data;
        logic [STRB_W-1:0]        strb;
        logic [DELAY_WIDTH-1:0]   aw_delay;
        logic [DELAY_WIDTH-1:0]   w_delay;
        logic [DELAY_WIDTH-1:0]   b_delay;
    } transfer_t;

    state_e                 state_q, state_d;
    transfer_t              xfer_q, xfer_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DELAY_WIDTH-1:0] aw_cnt_q, aw_cnt_d;
    logic [DELAY_WIDTH-1:0] w_cnt_q, w_cnt_d;
    logic [DELAY_WIDTH-1:0] b_cnt_q, b_cnt_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   bready_q, bready_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [1:0]             done_resp_q, done_resp_d;
    logic                   timeout_q, timeout_d;
    logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;

    logic [NUM_REQ-1:0]     win_onehot;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_valid;

    axi4_lite_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    always_comb begin
        state_d     = state_q;
        xfer_d      = xfer_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        aw_cnt_d    = aw_cnt_q;
        w_cnt_d     = w_cnt_q;
        b_cnt_d     = b_cnt_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        gnt_d       = '0;
        done_d      = '0;
        done_resp_d = done_resp_q;
        timeout_d   = timeout_q;
        wd_cnt_d    = wd_cnt_q;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    xfer_d.addr     = req_addr[int'(win_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    xfer_d.prot     = req_prot[int'(win_idx)*3 +: 3];
                    xfer_d.data     = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    xfer_d.strb     = req_strb[int'(win_idx)*STRB_W +: STRB_W];
                    xfer_d.aw_delay = awvalid_delay;
                    xfer_d.w_delay  = wvalid_delay;
                    xfer_d.b_delay  = bready_delay;
                    idx_d           = win_idx;
                    gnt_d           = win_onehot;
                    ptr_d           = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDX_W'(1);
                    timeout_d       = 1'b0;
                    wd_cnt_d        = '0;
                    aw_cnt_d        = awvalid_delay;
                    w_cnt_d         = wvalid_delay;
                    // Zero delay puts the valid up in the same cycle as gnt
                    awvalid_d       = (awvalid_delay == '0);
                    wvalid_d        = (wvalid_delay == '0);
                    aw_done_d       = 1'b0;
                    w_done_d        = 1'b0;
                    state_d         = ADDR_DATA;
                end
            end

            ADDR_DATA: begin
                if (aw_cnt_q != '0) begin
                    aw_cnt_d = aw_cnt_q - DELAY_WIDTH'(1);
                    if (aw_cnt_q == DELAY_WIDTH'(1)) begin
                        awvalid_d = 1'b1;
                    end
                end
                if (w_cnt_q != '0) begin
                    w_cnt_d = w_cnt_q - DELAY_WIDTH'(1);
                    if (w_cnt_q == DELAY_WIDTH'(1)) begin
                        wvalid_d = 1'b1;
                    end
                end
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    b_cnt_d  = xfer_q.b_delay;
                    bready_d = (xfer_q.b_delay == '0);
                    state_d  = RESP;
                end
            end

            RESP: begin
                if (b_cnt_q != '0) begin
                    b_cnt_d = b_cnt_q - DELAY_WIDTH'(1);
                    if (b_cnt_q == DELAY_WIDTH'(1)) begin
                        bready_d = 1'b1;
                    end
                end
                // Watchdog only flags; the write keeps waiting for bvalid
                if (!bvalid && (wd_cnt_q < WD_W'(MAX_WAIT_BVALID))) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                    if (wd_cnt_q == WD_W'(MAX_WAIT_BVALID - 1)) begin
                        timeout_d = 1'b1;
                    end
                end
                if (bready_q && bvalid) begin
                    done_resp_d   = bresp;
                    done_d[idx_q] = 1'b1;
                    bready_d      = 1'b0;
                    state_d       = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            xfer_q      <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
            aw_cnt_q    <= '0;
            w_cnt_q     <= '0;
            b_cnt_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
            done_resp_q <= '0;
            timeout_q   <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            xfer_q      <= xfer_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            aw_cnt_q    <= aw_cnt_d;
            w_cnt_q     <= w_cnt_d;
            b_cnt_q     <= b_cnt_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
            timeout_q   <= timeout_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign done_resp      = done_resp_q;
    assign bvalid_timeout = timeout_q;
    assign awaddr         = xfer_q.addr;
    assign awprot         = xfer_q.prot;
    assign awvalid        = awvalid_q;
    assign wdata          = xfer_q.data;
    assign wstrb          = xfer_q.strb;
    assign wvalid         = wvalid_q;
    assign bready         = bready_q;

endmodule
